pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 clk  in  1  single clock, all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous and active-low.
REQ-004 imem_req  out  1  instruction fetch request.
REQ-005 imem_addr  out  32  fetch address; always equals pc.
REQ-006 imem_gnt  in  1  memory accepts request this cycle.
REQ-007 imem_rvalid  in  1  fetch response valid.
REQ-008 imem_rdata  in  32  fetched instruction.
REQ-009 instr_valid  out  1  instruction available to decoder.
REQ-010 instr  out  32  held instruction.
REQ-011 instr_pc  out  32  address of held instruction.
REQ-012 dec_ready  in  1  decoder accepts instruction.
REQ-013 br_valid  in  1  execute stage resolved a branch/jump this cycle.
REQ-014 br_taken  in  1  resolved control transfer is taken.
REQ-015 br_target  in  32  taken target (PC+Imm or jump target).
REQ-016 pc_sel  out  1  next-PC mux select, 1 = target, 0 = PC+4; combinational.
REQ-017 flush  out  1  one-cycle pulse, downstream discards in-flight instruction.
REQ-018 misalign_err  out  1  one-cycle pulse, rejected misaligned target.

Function
REQ-019 States: IDLE, FETCH, WAIT, ISSUE, DRAIN; at most one outstanding fetch.
REQ-020 IDLE -> FETCH unconditionally on first clock after reset release.
REQ-021 FETCH: imem_req=1; imem_gnt -> WAIT; else stay FETCH with imem_addr stable.
REQ-022 WAIT: imem_req=0; on imem_rvalid capture instr<=imem_rdata, instr_pc<=pc, pc<=pc+4, -> ISSUE.
REQ-023 ISSUE: instr_valid=1, instr/instr_pc stable; dec_ready -> FETCH, instr_valid low next cycle.
REQ-024 instr_valid=1 only in ISSUE; minimum 3 cycles FETCH-to-ISSUE with gnt and rvalid each in first cycle.
REQ-025 pc+4 wraps modulo 2^32: 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-026 Redirect = br_valid && br_taken && br_target[1:0]==2'b00; pc_sel = redirect.
REQ-027 br_valid && !br_taken: no state or pc change; pc_sel=0.
REQ-028 Redirect in any non-IDLE state: pc<=br_target, flush=1 next cycle for exactly one cycle, instr_valid=0 next cycle.
REQ-029 Redirect next state: WAIT, or FETCH with imem_gnt same cycle -> DRAIN; FETCH without gnt, ISSUE, or WAIT with imem_rvalid same cycle -> FETCH.
REQ-030 WAIT with imem_rvalid and redirect same cycle: response discarded, no ISSUE, pc not incremented.
REQ-031 ISSUE with dec_ready and redirect same cycle: redirect wins, flush still pulses.
REQ-032 DRAIN: imem_req=0, next imem_rvalid discarded -> FETCH; redirect in DRAIN updates pc, stays DRAIN.
REQ-033 br_valid && br_taken && br_target[1:0]!=0: misalign_err=1 next cycle, redirect ignored, no flush.
REQ-034 Redirect in IDLE ignored.

Reset
REQ-035 rst_n low asynchronously: state IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, flush=0, misalign_err=0.
REQ-036 Reset mid-fetch: outstanding response after release is not captured; first request addresses RESET_PC.

Verification
REQ-037 Reset release, gnt/rvalid immediate, dec_ready=1 -> fetches 0x0,0x4,0x8; instr_valid every 3rd cycle.
REQ-038 imem_gnt held low 4 cycles in FETCH -> imem_req and imem_addr stable 4 cycles, no state advance.
REQ-039 br_taken target 0x100 while in WAIT -> flush one cycle, DRAIN drops next rdata, next imem_addr=0x100.
REQ-040 RESET_PC=32'hFFFF_FFFC, one instruction consumed -> next imem_addr=0x0.
REQ-041 br_taken target 0x102 -> misalign_err one cycle, pc unchanged, no flush; br_valid with br_taken=0 -> sequence uninterrupted.
REQ-042 rst_n asserted in ISSUE with dec_ready=0 -> instr_valid=0 immediately, pc=RESET_PC.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer for a single-issue in-order front end.
// It keeps at most one instruction fetch outstanding, holds the fetched
// instruction until the decoder takes it, and applies resolved branch/jump
// redirects. A response that belongs to a squashed fetch is dropped in DRAIN.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,

    // Instruction memory fetch port
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,

    // Decoder handoff
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        dec_ready,

    // Branch resolution from execute
    input  logic        br_valid,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        pc_sel,
    output logic        flush,
    output logic        misalign_err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_ISSUE = 3'd3,
        S_DRAIN = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        flush_q, flush_d;
    logic        misalign_q, misalign_d;

    logic        br_take;
    logic        br_aligned;
    logic        redirect;
    logic        redirect_act;
    logic [31:0] pc_plus4;

    // Classify the resolved branch: only a word-aligned taken target redirects.
    assign br_take      = br_valid && br_taken;
    assign br_aligned   = (br_target[1:0] == 2'b00);
    assign redirect     = br_take && br_aligned;
    // A redirect seen before the first fetch has started has nothing to steer.
    assign redirect_act = redirect && (state_q != S_IDLE);
    // Sequential increment wraps naturally at 2^32.
    assign pc_plus4     = pc_q + 32'd4;

    // Next-state, next-PC and capture logic.
    // NOTE: every signal gets a default at the top so no path can leave it
    // unassigned; that is what keeps this block free of inferred latches.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;

        unique case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                // Request stays up with a stable address until the memory grants.
                if (imem_gnt) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    instr_d    = imem_rdata;
                    instr_pc_d = pc_q;
                    pc_d       = pc_plus4;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (dec_ready) begin
                    state_d = S_FETCH;
                end
            end
            S_DRAIN: begin
                // Swallow the response of the squashed fetch.
                if (imem_rvalid) begin
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A redirect overrides normal sequencing. If a fetch is still in
        // flight (granted but not answered) its response must be drained.
        if (redirect_act) begin
            pc_d       = br_target;
            instr_d    = instr_q;
            instr_pc_d = instr_pc_q;
            unique case (state_q)
                S_FETCH: state_d = imem_gnt    ? S_DRAIN : S_FETCH;
                S_WAIT:  state_d = imem_rvalid ? S_FETCH : S_DRAIN;
                S_ISSUE: state_d = S_FETCH;
                // A redirect while draining keeps waiting for the stale
                // response unless it arrives in this very cycle.
                S_DRAIN: state_d = imem_rvalid ? S_FETCH : S_DRAIN;
                default: state_d = state_q;
            endcase
        end
    end

    // One-cycle status pulses, registered so they appear the cycle after the event.
    always_comb begin
        flush_d    = redirect_act;
        misalign_d = br_take && !br_aligned;
    end

    // State and datapath registers.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    // NOTE: the asynchronous reset clears the held instruction too, so the
    // decoder never sees stale data after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= 32'h0000_0000;
            instr_pc_q <= 32'h0000_0000;
            flush_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            flush_q    <= flush_d;
            misalign_q <= misalign_d;
        end
    end

    // Outputs are decoded straight from registers, never from inputs,
    // except the next-PC mux select which must act in the same cycle.
    assign imem_req     = (state_q == S_FETCH);
    assign imem_addr    = pc_q;
    assign instr_valid  = (state_q == S_ISSUE);
    assign instr        = instr_q;
    assign instr_pc     = instr_pc_q;
    assign flush        = flush_q;
    assign misalign_err = misalign_q;
    assign pc_sel       = redirect;

    // Structural invariants of the handshake.
    property p_req_excl_valid;
        @(posedge clk) disable iff (!rst_n) !(imem_req && instr_valid);
    endproperty
    a_req_excl_valid: assert property (p_req_excl_valid);

    property p_flush_excl_misalign;
        @(posedge clk) disable iff (!rst_n) !(flush && misalign_err);
    endproperty
    a_flush_excl_misalign: assert property (p_flush_excl_misalign);

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed, table-driven bench for pc_sequencer.
// Inputs change just after the falling edge; the combinational pc_sel is
// checked 1 ns later, registered outputs on the following falling edge.
module tb_pc_sequencer;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic        clk;
    logic        rst_n;
    logic        imem_gnt, imem_rvalid, dec_ready;
    logic        br_valid, br_taken;
    logic [31:0] imem_rdata, br_target;

    logic        imem_req, instr_valid, pc_sel, flush, misalign_err;
    logic [31:0] imem_addr, instr, instr_pc;

    logic        imem_req2, instr_valid2, pc_sel2, flush2, misalign_err2;
    logic [31:0] imem_addr2, instr2, instr_pc2;

    int n_cmp  = 0;
    int n_fail = 0;

    pc_sequencer #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .dec_ready(dec_ready),
        .br_valid(br_valid), .br_taken(br_taken), .br_target(br_target),
        .pc_sel(pc_sel), .flush(flush), .misalign_err(misalign_err)
    );

    // Second instance sharing all stimulus, used for the wrap-around case.
    pc_sequencer #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid2), .instr(instr2), .instr_pc(instr_pc2),
        .dec_ready(dec_ready),
        .br_valid(br_valid), .br_taken(br_taken), .br_target(br_target),
        .pc_sel(pc_sel2), .flush(flush2), .misalign_err(misalign_err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        rdy;
        logic        bv;
        logic        bt;
        logic [31:0] btgt;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_ivld;
        logic [31:0] e_instr;
        logic [31:0] e_ipc;
        logic        e_flush;
        logic        e_mis;
        logic        e_psel;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic g, input logic rv, input logic [31:0] rd,
                       input logic rdy, input logic bv, input logic bt,
                       input logic [31:0] tg,
                       input logic req, input logic [31:0] addr, input logic ivld,
                       input logic [31:0] ins, input logic [31:0] ipc,
                       input logic fl, input logic mis, input logic ps);
        vec_t v;
        v = '{g, rv, rd, rdy, bv, bt, tg, req, addr, ivld, ins, ipc, fl, mis, ps};
        vecs.push_back(v);
    endtask

    task automatic drive(input logic g, input logic rv, input logic [31:0] rd,
                         input logic rdy, input logic bv, input logic bt,
                         input logic [31:0] tg);
        imem_gnt    = g;
        imem_rvalid = rv;
        imem_rdata  = rd;
        dec_ready   = rdy;
        br_valid    = bv;
        br_taken    = bt;
        br_target   = tg;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        //   gnt rv rdata         rdy bv bt target        | req addr          ivld instr         ipc           fl mis psel
        add(L, L, 32'h0,        L, L, L, 32'h0,     H, 32'h0000_0000, L, 32'h0,         32'h0,   L, L, L); // 0  IDLE->FETCH
        add(H, L, 32'h0,        L, L, L, 32'h0,     L, 32'h0000_0000, L, 32'h0,         32'h0,   L, L, L); // 1  grant -> WAIT
        add(L, H, 32'hAAAA0001, L, L, L, 32'h0,     L, 32'h0000_0004, H, 32'hAAAA0001, 32'h0,   L, L, L); // 2  capture @0
        add(L, L, 32'h0,        H, L, L, 32'h0,     H, 32'h0000_0004, L, 32'hAAAA0001, 32'h0,   L, L, L); // 3  consumed
        add(H, L, 32'h0,        L, L, L, 32'h0,     L, 32'h0000_0004, L, 32'hAAAA0001, 32'h0,   L, L, L); // 4
        add(L, H, 32'hBBBB0002, L, L, L, 32'h0,     L, 32'h0000_0008, H, 32'hBBBB0002, 32'h4,   L, L, L); // 5  capture @4
        add(L, L, 32'h0,        H, L, L, 32'h0,     H, 32'h0000_0008, L, 32'hBBBB0002, 32'h4,   L, L, L); // 6
        add(H, L, 32'h0,        L, L, L, 32'h0,     L, 32'h0000_0008, L, 32'hBBBB0002, 32'h4,   L, L, L); // 7
        add(L, H, 32'hCCCC0003, L, L, L, 32'h0,     L, 32'h0000_000C, H, 32'hCCCC0003, 32'h8,   L, L, L); // 8  capture @8
        add(L, L, 32'h0,        L, L, L, 32'h0,     L, 32'h0000_000C, H, 32'hCCCC0003, 32'h8,   L, L, L); // 9  decoder stalls
        add(L, L, 32'h0,        H, L, L, 32'h0,     H, 32'h0000_000C, L, 32'hCCCC0003, 32'h8,   L, L, L); // 10
        add(L, L, 32'h0,        L, L, L, 32'h0,     H, 32'h0000_000C, L, 32'hCCCC0003, 32'h8,   L, L, L); // 11 no grant x4
        add(L, L, 32'h0,        L, L, L, 32'h0,     H, 32'h0000_000C, L, 32'hCCCC0003, 32'h8,   L, L, L); // 12
        add(L, L, 32'h0,        L, L, L, 32'h0,     H, 32'h0000_000C, L, 32'hCCCC0003, 32'h8,   L, L, L); // 13
        add(L, L, 32'h0,        L, L, L, 32'h0,     H, 32'h0000_000C, L, 32'hCCCC0003, 32'h8,   L, L, L); // 14
        add(H, L, 32'h0,        L, H, L, 32'h200,   L, 32'h0000_000C, L, 32'hCCCC0003, 32'h8,   L, L, L); // 15 not-taken ignored
        add(L, L, 32'h0,        L, H, H, 32'h100,   L, 32'h0000_0100, L, 32'hCCCC0003, 32'h8,   H, L, H); // 16 redirect in WAIT
        add(L, H, 32'hDEADBEEF, L, L, L, 32'h0,     H, 32'h0000_0100, L, 32'hCCCC0003, 32'h8,   L, L, L); // 17 drained
        add(H, L, 32'h0,        L, L, L, 32'h0,     L, 32'h0000_0100, L, 32'hCCCC0003, 32'h8,   L, L, L); // 18
        add(L, H, 32'h11110005, L, L, L, 32'h0,     L, 32'h0000_0104, H, 32'h11110005, 32'h100, L, L, L); // 19 capture @100
        add(L, L, 32'h0,        L, H, H, 32'h102,   L, 32'h0000_0104, H, 32'h11110005, 32'h100, L, H, L); // 20 misaligned
        add(L, L, 32'h0,        L, L, L, 32'h0,     L, 32'h0000_0104, H, 32'h11110005, 32'h100, L, L, L); // 21 pulse ends
        add(L, L, 32'h0,        H, H, H, 32'h40,    H, 32'h0000_0040, L, 32'h11110005, 32'h100, H, L, H); // 22 ready+redirect
        add(L, L, 32'h0,        L, L, L, 32'h0,     H, 32'h0000_0040, L, 32'h11110005, 32'h100, L, L, L); // 23
        add(H, L, 32'h0,        L, H, H, 32'h80,    L, 32'h0000_0080, L, 32'h11110005, 32'h100, H, L, H); // 24 FETCH+gnt redirect
        add(L, L, 32'h0,        L, H, H, 32'hC0,    L, 32'h0000_00C0, L, 32'h11110005, 32'h100, H, L, H); // 25 redirect in DRAIN
        add(L, H, 32'h12345678, L, L, L, 32'h0,     H, 32'h0000_00C0, L, 32'h11110005, 32'h100, L, L, L); // 26 drained
        add(L, L, 32'h0,        L, H, H, 32'h10,    H, 32'h0000_0010, L, 32'h11110005, 32'h100, H, L, H); // 27 FETCH no gnt redirect
        add(H, L, 32'h0,        L, L, L, 32'h0,     L, 32'h0000_0010, L, 32'h11110005, 32'h100, L, L, L); // 28
        add(L, H, 32'h99999999, L, H, H, 32'h20,    H, 32'h0000_0020, L, 32'h11110005, 32'h100, H, L, H); // 29 rvalid+redirect
        add(H, L, 32'h0,        L, L, L, 32'h0,     L, 32'h0000_0020, L, 32'h11110005, 32'h100, L, L, L); // 30
        add(L, H, 32'h22220006, L, L, L, 32'h0,     L, 32'h0000_0024, H, 32'h22220006, 32'h20,  L, L, L); // 31 capture @20
        add(L, L, 32'h0,        H, L, L, 32'h0,     H, 32'h0000_0024, L, 32'h22220006, 32'h20,  L, L, L); // 32

        // Reset state
        rst_n = 1'b0;
        drive(L, L, 32'h0, L, L, L, 32'h0);
        repeat (2) @(negedge clk);
        check("rst.req",      imem_req,      L);
        check("rst.addr",     imem_addr,     32'h0);
        check("rst.ivld",     instr_valid,   L);
        check("rst.instr",    instr,         32'h0);
        check("rst.ipc",      instr_pc,      32'h0);
        check("rst.flush",    flush,         L);
        check("rst.mis",      misalign_err,  L);
        check("rst.psel",     pc_sel,        L);
        check("rst2.addr",    imem_addr2,    32'hFFFF_FFFC);
        check("rst2.req",     imem_req2,     L);
        check("rst2.ivld",    instr_valid2,  L);
        check("rst2.instr",   instr2,        32'h0);
        check("rst2.flush",   flush2,        L);
        check("rst2.mis",     misalign_err2, L);
        check("rst2.psel",    pc_sel2,       L);
        rst_n = 1'b1;

        // Table-driven sequence
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].gnt, vecs[i].rv, vecs[i].rdata, vecs[i].rdy,
                  vecs[i].bv, vecs[i].bt, vecs[i].btgt);
            #1;
            check($sformatf("v%0d.psel", i), pc_sel, vecs[i].e_psel);
            step();
            check($sformatf("v%0d.req", i),   imem_req,     vecs[i].e_req);
            check($sformatf("v%0d.addr", i),  imem_addr,    vecs[i].e_addr);
            check($sformatf("v%0d.ivld", i),  instr_valid,  vecs[i].e_ivld);
            check($sformatf("v%0d.instr", i), instr,        vecs[i].e_instr);
            check($sformatf("v%0d.ipc", i),   instr_pc,     vecs[i].e_ipc);
            check($sformatf("v%0d.flush", i), flush,        vecs[i].e_flush);
            check($sformatf("v%0d.mis", i),   misalign_err, vecs[i].e_mis);
            if (i == 2) begin
                // Wrap instance fetched from 0xFFFF_FFFC; next address wraps to 0.
                check("wrap.ipc",  instr_pc2,  32'hFFFF_FFFC);
                check("wrap.addr", imem_addr2, 32'h0000_0000);
            end
        end

        // Reach ISSUE again (pc=0x24), waiting for instr_valid with a bound.
        drive(H, L, 32'h0, L, L, L, 32'h0);
        step();
        drive(L, H, 32'h33330007, L, L, L, 32'h0);
        step();
        drive(L, L, 32'h0, L, L, L, 32'h0);
        begin
            int budget = 8;
            while (!instr_valid && budget > 0) begin
                step();
                budget--;
            end
        end
        check("seq.issue_ivld", instr_valid, H);
        check("seq.issue_ipc",  instr_pc,    32'h24);

        // Asynchronous reset while holding an instruction in ISSUE.
        #2 rst_n = 1'b0;
        #1;
        check("arst.ivld",  instr_valid, L);
        check("arst.addr",  imem_addr,   32'h0);
        check("arst.req",   imem_req,    L);
        check("arst.instr", instr,       32'h0);

        // Release with a stale response still arriving: it must not be captured.
        @(negedge clk);
        drive(L, H, 32'h55555555, L, L, L, 32'h0);
        rst_n = 1'b1;
        step();
        check("rel.req",   imem_req,    H);
        check("rel.addr",  imem_addr,   32'h0);
        step();
        check("rel.ivld",  instr_valid, L);
        check("rel.instr", instr,       32'h0);
        check("rel.req2",  imem_req,    H);
        drive(H, L, 32'h0, L, L, L, 32'h0);
        step();
        drive(L, H, 32'h66660008, L, L, L, 32'h0);
        step();
        check("rel.cap_instr", instr,       32'h66660008);
        check("rel.cap_ipc",   instr_pc,    32'h0);
        check("rel.cap_ivld",  instr_valid, H);
        check("rel.cap_addr",  imem_addr,   32'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
